// File: rtl/latch_mem_read_port.sv
// Pipelined read port for the standard-cell latch memory array: binary decode,
// registered word-line select, registered data, valid/ready flow control.
module latch_mem_read_port #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [DEPTH*WIDTH-1:0] MEM_Q,
   input  logic                   RD_VALID,
   output logic                   RD_READY,
   input  logic [AW-1:0]          RD_ADDR,
   output logic [DEPTH-1:0]       RWL,
   output logic [WIDTH-1:0]       DOUT,
   output logic                   DOUT_VALID,
   input  logic                   DOUT_READY,
   output logic                   DOUT_ERR
);

   logic             v1;
   logic             err1;
   logic             s2_free;
   logic             s1_adv;
   logic             accept;
   logic [DEPTH-1:0] addr_dec;
   logic             addr_oob;
   logic [WIDTH-1:0] rd_word;

   assign s2_free  = !DOUT_VALID || DOUT_READY;
   assign s1_adv   = v1 && s2_free;
   assign RD_READY = !v1 || s1_adv;
   assign accept   = RD_VALID && RD_READY;

   // An address matching no word leaves the decode all-zero and flags out-of-range.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      addr_dec = '0;
      addr_oob = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(RD_ADDR) == i) begin
            addr_dec[i] = 1'b1;
            addr_oob    = 1'b0;
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_word = rd_word | (MEM_Q[i*WIDTH +: WIDTH] & {WIDTH{RWL[i]}});
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         v1         <= 1'b0;
         err1       <= 1'b0;
         RWL        <= '0;
         DOUT       <= '0;
         DOUT_VALID <= 1'b0;
         DOUT_ERR   <= 1'b0;
      end else begin
         // Stage 1: load on accept, otherwise drop the word-line once the entry moves on.
         if (accept) begin
            v1   <= 1'b1;
            err1 <= addr_oob;
            RWL  <= addr_dec;
         end else if (s1_adv) begin
            v1   <= 1'b0;
            err1 <= 1'b0;
            RWL  <= '0;
         end

         // Stage 2: MEM_Q is sampled only on the load edge; DOUT keeps its value afterwards.
         if (s1_adv) begin
            DOUT       <= rd_word;
            DOUT_ERR   <= err1;
            DOUT_VALID <= 1'b1;
         end else if (DOUT_READY) begin
            DOUT_VALID <= 1'b0;
            DOUT_ERR   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_latch_mem_read_port.sv
// Self-checking bench: DEPTH=4 and DEPTH=5 ports driven in lockstep, checked
// against a transaction-queue model plus directed spot checks.
module tb_latch_mem_read_port;

   typedef struct {
      logic [2:0] addr;
      int         vis;
      bit         cap;
      logic [7:0] data;
      logic       err;
   } txn_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rd_valid;
   logic       dout_ready;
   logic [1:0] addr4;
   logic [2:0] addr5;
   logic [7:0] w4 [4];
   logic [7:0] w5 [5];
   logic [31:0] mem_q4;
   logic [39:0] mem_q5;

   logic       rd_ready4, dout_valid4, dout_err4;
   logic [3:0] rwl4;
   logic [7:0] dout4;
   logic       rd_ready5, dout_valid5, dout_err5;
   logic [4:0] rwl5;
   logic [7:0] dout5;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   txn_t mq [2][$];

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) mem_q4[i*8 +: 8] = w4[i];
      for (int i = 0; i < 5; i++) mem_q5[i*8 +: 8] = w5[i];
   end

   latch_mem_read_port #(.WIDTH(8), .DEPTH(4)) dut4 (
      .CLK(clk), .RST(rst), .MEM_Q(mem_q4), .RD_VALID(rd_valid), .RD_READY(rd_ready4),
      .RD_ADDR(addr4), .RWL(rwl4), .DOUT(dout4), .DOUT_VALID(dout_valid4),
      .DOUT_READY(dout_ready), .DOUT_ERR(dout_err4)
   );

   latch_mem_read_port #(.WIDTH(8), .DEPTH(5)) dut5 (
      .CLK(clk), .RST(rst), .MEM_Q(mem_q5), .RD_VALID(rd_valid), .RD_READY(rd_ready5),
      .RD_ADDR(addr5), .RWL(rwl5), .DOUT(dout5), .DOUT_VALID(dout_valid5),
      .DOUT_READY(dout_ready), .DOUT_ERR(dout_err5)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] word(input int k, input int a);
      if (k == 0) return w4[a];
      return w5[a];
   endfunction

   // One clock: drive inputs, compare outputs with the model, advance the model, clock.
   task automatic step(input logic v, input logic [1:0] a4, input logic [2:0] a5,
                       input logic dr, input logic r);
      bit   rdy_exp, dv_exp;
      int   depth;
      txn_t t, h;
      logic obs_rdy, obs_dv, obs_err;
      logic [7:0] obs_dout;
      rd_valid   = v;
      addr4      = a4;
      addr5      = a5;
      dout_ready = dr;
      rst        = r;
      #1;
      for (int k = 0; k < 2; k++) begin
         depth    = (k == 0) ? 4 : 5;
         obs_rdy  = (k == 0) ? rd_ready4   : rd_ready5;
         obs_dv   = (k == 0) ? dout_valid4 : dout_valid5;
         obs_err  = (k == 0) ? dout_err4   : dout_err5;
         obs_dout = (k == 0) ? dout4       : dout5;
         rdy_exp  = (mq[k].size() < 2) || dr;
         dv_exp   = (mq[k].size() > 0) && (mq[k][0].vis <= cyc);
         check($sformatf("rd_ready_d%0d", depth), 64'(obs_rdy), 64'(rdy_exp));
         check($sformatf("dout_valid_d%0d", depth), 64'(obs_dv), 64'(dv_exp));
         if (dv_exp) begin
            check($sformatf("dout_d%0d", depth), 64'(obs_dout), 64'(mq[k][0].data));
            check($sformatf("dout_err_d%0d", depth), 64'(obs_err), 64'(mq[k][0].err));
         end else begin
            check($sformatf("err_wo_valid_d%0d", depth), 64'(obs_err), 64'(0));
         end
         if (r) begin
            mq[k].delete();
         end else begin
            if (dv_exp && dr) void'(mq[k].pop_front());
            if (v && rdy_exp) begin
               t.addr = (k == 0) ? {1'b0, a4} : a5;
               t.vis  = cyc + 2;
               t.cap  = 1'b0;
               t.data = 8'h00;
               t.err  = 1'b0;
               mq[k].push_back(t);
            end
            // The head takes its data from the memory as it stands at the edge it becomes visible.
            if (mq[k].size() > 0 && !mq[k][0].cap && mq[k][0].vis <= cyc + 1) begin
               h      = mq[k].pop_front();
               h.err  = (int'(h.addr) >= depth);
               h.data = h.err ? 8'h00 : word(k, int'(h.addr));
               h.cap  = 1'b1;
               mq[k].push_front(h);
            end
         end
      end
      check("rwl_onehot0_d4", 64'($onehot0(rwl4)), 64'(1));
      check("rwl_onehot0_d5", 64'($onehot0(rwl5)), 64'(1));
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
   endtask

   initial begin
      rst        = 1'b1;
      rd_valid   = 1'b0;
      dout_ready = 1'b1;
      addr4      = '0;
      addr5      = '0;
      for (int i = 0; i < 4; i++) w4[i] = 8'hA0 + 8'(i);
      for (int i = 0; i < 5; i++) w5[i] = 8'hA0 + 8'(i);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_rwl", 64'(rwl4), 64'(0));
      check("reset_dout", 64'(dout4), 64'(0));
      check("reset_dout_valid", 64'(dout_valid4), 64'(0));
      check("reset_dout_err", 64'(dout_err4), 64'(0));
      check("reset_rd_ready", 64'(rd_ready4), 64'(1));
      @(negedge clk);

      // Single read
      step(1'b1, 2'd2, 3'd2, 1'b1, 1'b0);
      check("single_rwl_t1", 64'(rwl4), 64'(4'b0100));
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
      check("single_dout_t2", 64'(dout4), 64'(8'hA2));
      check("single_valid_t2", 64'(dout_valid4), 64'(1));
      check("single_rwl_t2", 64'(rwl4), 64'(0));
      idle(2);

      // Streaming at full rate
      for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 3'(i), 1'b1, 1'b0);
      check("stream_dout_a2", 64'(dout4), 64'(8'hA2));
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
      check("stream_dout_a3", 64'(dout4), 64'(8'hA3));
      idle(2);

      // Back-pressure
      step(1'b1, 2'd0, 3'd0, 1'b0, 1'b0);
      step(1'b1, 2'd1, 3'd1, 1'b0, 1'b0);
      step(1'b1, 2'd2, 3'd2, 1'b0, 1'b0);
      step(1'b1, 2'd2, 3'd2, 1'b0, 1'b0);
      check("bp_dout_hold", 64'(dout4), 64'(8'hA0));
      check("bp_rwl_hold", 64'(rwl4), 64'(4'b0010));
      check("bp_rd_ready", 64'(rd_ready4), 64'(0));
      step(1'b1, 2'd2, 3'd2, 1'b1, 1'b0);
      check("bp_release_a1", 64'(dout4), 64'(8'hA1));
      idle(4);

      // Out-of-range address on the DEPTH=5 port
      step(1'b1, 2'd0, 3'd7, 1'b1, 1'b0);
      check("oob_rwl", 64'(rwl5), 64'(0));
      step(1'b1, 2'd0, 3'd4, 1'b1, 1'b0);
      check("oob_dout", 64'(dout5), 64'(0));
      check("oob_valid", 64'(dout_valid5), 64'(1));
      check("oob_err", 64'(dout_err5), 64'(1));
      check("oob_next_rwl", 64'(rwl5), 64'(5'b10000));
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
      check("oob_next_dout", 64'(dout5), 64'(8'hA4));
      check("oob_next_err", 64'(dout_err5), 64'(0));
      idle(2);

      // Memory changes between accept and data load
      step(1'b1, 2'd1, 3'd1, 1'b1, 1'b0);
      w4[1] = 8'h5C;
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
      check("capture_dout", 64'(dout4), 64'(8'h5C));
      idle(2);
      w4[1] = 8'hA1;

      // Reset with two reads in flight
      step(1'b1, 2'd0, 3'd0, 1'b1, 1'b0);
      step(1'b1, 2'd3, 3'd3, 1'b1, 1'b0);
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
      rst = 1'b0;
      #1;
      check("midrst_rwl", 64'(rwl4), 64'(0));
      check("midrst_dout", 64'(dout4), 64'(0));
      check("midrst_valid", 64'(dout_valid4), 64'(0));
      check("midrst_err", 64'(dout_err4), 64'(0));
      check("midrst_rd_ready", 64'(rd_ready4), 64'(1));
      idle(3);

      // Randomised traffic with occasional resets and memory updates
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(3) == 0) w4[$urandom_range(3)] = 8'($urandom);
         if ($urandom_range(3) == 0) w5[$urandom_range(4)] = 8'($urandom);
         step(1'($urandom_range(3) != 0), 2'($urandom_range(3)), 3'($urandom_range(7)),
              1'($urandom_range(2) != 0), 1'($urandom_range(59) == 0));
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
